// File: rtl/btn_cmd_scheduler_pkg.sv
// Shared definitions for the button command scheduler.
//   - Button index constants for the five game buttons.
//   - Scheduler FSM state type.
package btn_cmd_scheduler_pkg;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_FIRE  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_HOLD  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/btn_cmd_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector, bit i = requester i
//   ptr     : highest-priority index (0..N-1)
//   gnt_id  : first requesting index at or after ptr, wrapping modulo N
//   gnt_any : at least one request present
module rr_arbiter #(
  parameter int unsigned N    = 5,
  parameter int unsigned ID_W = 3
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_any
);

  logic [N-1:0] upper;

  // Requests at or above ptr take priority; if none, fall back to the
  // lowest request overall, which is the wrap-around case.
  always_comb begin
    upper = '0;
    for (int unsigned j = 0; j < N; j++) begin
      upper[j] = req[j] && (j >= 32'(ptr));
    end
  end

  always_comb begin
    gnt_any = |req;
    gnt_id  = '0;
    // Descending scan so the lowest matching index is written last.
    if (|upper) begin
      for (int unsigned j = N; j > 0; j--) begin
        if (upper[j-1]) gnt_id = ID_W'(j - 1);
      end
    end else begin
      for (int unsigned j = N; j > 0; j--) begin
        if (req[j-1]) gnt_id = ID_W'(j - 1);
      end
    end
  end

endmodule

// File: rtl/btn_cmd_scheduler.sv
// Serialises one-cycle button press pulses into a single command stream.
//   clk       : clock shared with the debouncer bank
//   rst       : synchronous active-high reset
//   btn_pulse : one-cycle press pulses, bit i = button i
//   cmd_ready : consumer accepts the offered command this cycle
//   cmd_valid : a command is offered
//   cmd_id    : index of the offered button, 0 when nothing is offered
//   pending   : latched presses not yet accepted
//   overrun   : sticky; a press arrived for a button already pending
module btn_cmd_scheduler
  import btn_cmd_scheduler_pkg::*;
#(
  parameter int unsigned N_BTN   = 5,
  parameter int unsigned ID_W    = 3,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_pulse,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [ID_W-1:0]  cmd_id,
  output logic [N_BTN-1:0] pending,
  output logic             overrun
);

  localparam logic [3:0] HOLD_LAST = 4'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [N_BTN-1:0] ONE = N_BTN'(1);

  sched_state_e     state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic [ID_W-1:0]  rr_ptr, ptr_d;
  logic [ID_W-1:0]  id_d;
  logic             accept;
  logic [N_BTN-1:0] clr;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_any;

  rr_arbiter #(
    .N    (N_BTN),
    .ID_W (ID_W)
  ) u_arb (
    .req     (pending),
    .ptr     (rr_ptr),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  assign cmd_valid = (state_q == ST_OFFER);
  assign clr       = accept ? (ONE << cmd_id) : '0;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    id_d    = cmd_id;
    ptr_d   = rr_ptr;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          state_d = ST_OFFER;
          id_d    = gnt_id;
        end
      end
      ST_OFFER: begin
        if (cmd_ready) begin
          accept = 1'b1;
          id_d   = '0;
          ptr_d  = (cmd_id == ID_W'(N_BTN - 1)) ? '0 : cmd_id + 1'b1;
          hold_d = '0;
          state_d = (HOLDOFF > 0) ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = ST_IDLE;
        else                     hold_d  = hold_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A pulse landing on the bit being cleared re-queues it: the OR with
  // btn_pulse comes after the clear, and overrun masks the cleared bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      rr_ptr  <= '0;
      cmd_id  <= '0;
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rr_ptr  <= ptr_d;
      cmd_id  <= id_d;
      pending <= (pending & ~clr) | btn_pulse;
      if (|(btn_pulse & pending & ~clr)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_btn_cmd_scheduler.sv
module tb_btn_cmd_scheduler;
  import btn_cmd_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn_pulse;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_id;
  logic [4:0] pending;
  logic       overrun;

  int total = 0;
  int bad   = 0;
  int n;
  int seen;

  btn_cmd_scheduler #(
    .N_BTN   (5),
    .ID_W    (3),
    .HOLDOFF (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_pulse (btn_pulse),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_id    (cmd_id),
    .pending   (pending),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until cmd_valid rises or the budget runs out; n = edges taken.
  task automatic wait_valid(input int max, output int cnt);
    cnt = 0;
    while (!cmd_valid && cnt < max) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; btn_pulse = 5'b11111; cmd_ready = 1'b0;

    // Reset held for two edges with all buttons pulsing.
    tick();
    check("rst1_valid", 32'(cmd_valid), 0);
    check("rst1_pending", 32'(pending), 0);
    tick();
    check("rst2_id", 32'(cmd_id), 0);
    check("rst2_pending", 32'(pending), 0);
    check("rst2_overrun", 32'(overrun), 0);
    rst = 1'b0;
    tick();
    check("rel_pending", 32'(pending), 32'h1f);
    check("rel_valid", 32'(cmd_valid), 0);
    btn_pulse = '0;
    tick();
    check("rel_offer_valid", 32'(cmd_valid), 1);
    check("rel_offer_id", 32'(cmd_id), 0);
    // Reset mid-offer drops the command and every pending press.
    rst = 1'b1;
    tick();
    check("midrst_valid", 32'(cmd_valid), 0);
    check("midrst_pending", 32'(pending), 0);
    rst = 1'b0;
    tick();

    // Single press of fire.
    cmd_ready = 1'b1;
    btn_pulse = 5'(1 << BTN_FIRE);
    tick();
    btn_pulse = '0;
    check("single_lat1_valid", 32'(cmd_valid), 0);
    tick();
    check("single_valid", 32'(cmd_valid), 1);
    check("single_id", 32'(cmd_id), BTN_FIRE);
    tick();
    check("single_hold1_valid", 32'(cmd_valid), 0);
    check("single_hold1_id", 32'(cmd_id), 0);
    check("single_pending", 32'(pending), 0);
    tick();
    check("single_hold2_valid", 32'(cmd_valid), 0);
    tick();
    check("single_idle_valid", 32'(cmd_valid), 0);

    // Round-robin: ids 0 then 2, then re-pulse with ptr=3 wraps to 0.
    btn_pulse = 5'b00101;
    tick();
    btn_pulse = '0;
    tick();
    check("rr_first_id", 32'(cmd_id), 0);
    check("rr_first_valid", 32'(cmd_valid), 1);
    tick();
    wait_valid(8, n);
    check("rr_second_gap", 32'(n), 3);
    check("rr_second_id", 32'(cmd_id), 2);
    tick();
    btn_pulse = 5'b00101;
    tick();
    btn_pulse = '0;
    wait_valid(8, n);
    check("rr_wrap_gap", 32'(n), 2);
    check("rr_wrap_id", 32'(cmd_id), 0);
    tick();
    wait_valid(8, n);
    check("rr_last_id", 32'(cmd_id), 2);
    tick(); tick(); tick();
    check("rr_drain_pending", 32'(pending), 0);
    check("rr_drain_valid", 32'(cmd_valid), 0);

    // Backpressure: id 1 held while bit 3 is pressed.
    cmd_ready = 1'b0;
    btn_pulse = 5'(1 << BTN_DOWN);
    tick();
    btn_pulse = '0;
    tick();
    check("bp_id", 32'(cmd_id), BTN_DOWN);
    btn_pulse = 5'(1 << BTN_RIGHT);
    tick();
    btn_pulse = '0;
    seen = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (cmd_valid !== 1'b1 || cmd_id !== 3'd1) seen++;
    end
    check("bp_stable_violations", 32'(seen), 0);
    check("bp_pending", 32'(pending), 32'h0a);
    cmd_ready = 1'b1;
    tick();
    check("bp_accept_valid", 32'(cmd_valid), 0);
    wait_valid(8, n);
    check("bp_next_gap", 32'(n), 3);
    check("bp_next_id", 32'(cmd_id), BTN_RIGHT);
    tick(); tick(); tick();

    // Set/clear collision on bit 1.
    cmd_ready = 1'b0;
    btn_pulse = 5'(1 << BTN_DOWN);
    tick();
    btn_pulse = '0;
    tick();
    check("col_id", 32'(cmd_id), BTN_DOWN);
    cmd_ready = 1'b1;
    btn_pulse = 5'(1 << BTN_DOWN);
    tick();
    btn_pulse = '0;
    check("col_pending", 32'(pending), 32'h02);
    check("col_overrun", 32'(overrun), 0);
    wait_valid(8, n);
    check("col_reoffer_gap", 32'(n), 3);
    check("col_reoffer_id", 32'(cmd_id), BTN_DOWN);
    tick(); tick(); tick();
    check("col_drain_pending", 32'(pending), 0);

    // Overrun: bit 2 pressed twice while pending.
    cmd_ready = 1'b0;
    btn_pulse = 5'(1 << BTN_LEFT);
    tick();
    check("ovr_not_yet", 32'(overrun), 0);
    tick();
    btn_pulse = '0;
    check("ovr_set", 32'(overrun), 1);
    check("ovr_offer_id", 32'(cmd_id), BTN_LEFT);
    cmd_ready = 1'b1;
    tick();
    check("ovr_pending", 32'(pending), 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cmd_valid) seen++;
    end
    check("ovr_extra_cmds", 32'(seen), 0);
    check("ovr_sticky", 32'(overrun), 1);
    rst = 1'b1;
    tick();
    check("ovr_rst_clear", 32'(overrun), 0);
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
